riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
- Parametrised multi-cycle load/store unit between the core datapath and the data-memory/IO bridge.
- Replaces the single-cycle combinational load-extension path with a registered request/response handshake to a variable-latency memory port.
- Adds byte-enable generation, byte-lane steering, misalignment detection and an access timeout.
- Supports XLEN 32 or 64, so the same block serves the next core generation.

Parameters:
- XLEN, 32, data width; legal values are 32 and 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum number of cycles mem_req waits for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset: the block resets on a clk rising edge while rst=0.
- req_valid  in  1  core requests an access.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
- req_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; response is ready.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  2  00=ok, 01=misaligned/illegal size, 10=timeout.
- mem_req  out  1  memory access strobe, held until mem_ack.
- mem_we  out  1  write strobe.
- mem_be  out  XLEN/8  byte enables.
- mem_addr  out  ADDR_W  XLEN/8-aligned address: low log2(XLEN/8) bits forced to 0.
- mem_wdata  out  XLEN  lane-steered store data.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  XLEN  raw memory word.

Behaviour:
- Reset values: FSM=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=00; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; timeout counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. The request is accepted on req_valid&&req_ready. All request fields are registered at acceptance.
  - Misaligned if addr mod (1<<size) != 0. Illegal if size=3 with XLEN=32. In either case go to RESP with err=01 and issue no mem_req.
  - Otherwise go to ACCESS.
- ACCESS:
  - req_ready=0 and mem_req=1.
  - mem_addr, mem_we, mem_be and mem_wdata are driven from registers and are stable for the whole state.
  - The counter increments each cycle.
  - mem_ack=1: capture mem_rdata and go to RESP with err=00.
  - Counter reaches TIMEOUT with no ack (TIMEOUT>0): deassert mem_req and go to RESP with err=10.
  - Ack and timeout in the same cycle: the ack wins.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 in RESP, so back-to-back accesses have a 3-cycle minimum (accept, ACCESS with immediate ack, RESP).
- Latency: resp_valid asserts 1 cycle after the ack cycle; for errors, 1 cycle after acceptance.
- Store steering (off = addr[log2(XLEN/8)-1:0]):
  - mem_be = ((1<<(1<<size))-1) << off.
  - mem_wdata = req_wdata << (8*off). Bytes outside mem_be are don't care but are driven deterministically by the shift.
- Load extraction:
  - shifted = captured_rdata >> (8*off).
  - Take the low 8/16/32/64 bits per size, then sign-extend from the top bit of that field or zero-extend when req_unsigned. The sign bit is bit 7 for a byte access.
  - Loads set mem_be to the same mask as a store of that size.
- Stores return resp_rdata=0 and do not touch memory data on error.
- mem_ack outside ACCESS, including a late ack after timeout, is ignored.
- req_valid while req_ready=0 is ignored; the core holds it.
- rst=0 at any edge: return to IDLE and clear all outputs the same cycle. An in-flight mem_req drops on that edge and no response is produced.
- Counter width is clog2(TIMEOUT+1); the counter clears on entry to ACCESS.

Test Plan:
- XLEN=32, store word 0xDEADBEEF @0x104, ack after 3 cycles -> mem_be=1111, mem_addr=0x104, mem_req high 3 cycles; resp_valid 1 cycle after ack, err=00, rdata=0.
- Load byte signed @0x103, mem_rdata=0x80112233 with immediate ack -> rdata=0xFFFFFF80; the same access with req_unsigned=1 -> 0x00000080; mem_be=1000.
- Store half 0x1234 @0x102 -> mem_be=1100, mem_wdata[31:16]=0x1234; load half @0x101 -> resp_err=01 one cycle after acceptance, mem_req never asserts.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then resp err=10; an ack injected 2 cycles later is ignored and req_ready=1.
- XLEN=64, load double @0x8 returning 0x0123456789ABCDEF -> same value, mem_be=0xFF; size=3 with XLEN=32 -> err=01.
- rst=0 during ACCESS -> the next cycle mem_req=0, req_ready=1, no resp_valid; after rst=1 a fresh load completes normally.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: core request/response and data-memory bus bundle for the load/store unit
interface riscv_lsu_if #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [1:0]        resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle load/store unit with lane steering, misalignment check and access timeout
module riscv_lsu #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  riscv_lsu_if.slave  bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q, err_q;
  logic [OW-1:0]     off_q, off;
  logic [NB-1:0]     be_q, mask;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, rdata_q, sh, sl, ext;
  logic [7:0]        amt;
  logic              bad, accept, expire;
  always_comb begin
    off = bus.req_addr[OW-1:0];
    mask = NB'((16'd1 << (5'd1 << bus.req_size)) - 16'd1);
    bad = |(bus.req_addr[2:0] & ((3'd1 << bus.req_size) - 3'd1)) || (bus.req_size == 2'd3 && XLEN == 32);
    accept = state_q == IDLE && bus.req_valid;
    expire = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
    // move the addressed field to the top, then shift back down to extend it
    sh = bus.mem_rdata >> {off_q, 3'b000};
    amt = 8'(XLEN) - (8'd8 << size_q);
    sl = sh << amt;
    ext = uns_q ? sl >> amt : XLEN'($signed(sl) >>> amt);
    state_d = accept ? (bad ? RESP : ACCESS)
            : state_q == ACCESS && (bus.mem_ack || expire) ? RESP
            : state_q == RESP ? IDLE : state_q;
  end
  always_ff @(posedge clk) state_q <= !rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      err_q <= '0;
      off_q <= '0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      we_q <= bus.req_we;
      uns_q <= bus.req_unsigned;
      size_q <= bus.req_size;
      err_q <= bad ? 2'b01 : 2'b00;
      off_q <= off;
      be_q <= mask << off;
      addr_q <= bus.req_addr & ~ADDR_W'(NB - 1);
      wdata_q <= bus.req_wdata << {off, 3'b000};
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + CW'(1);
      if (bus.mem_ack) rdata_q <= we_q ? '0 : ext;
      else if (expire) err_q <= 2'b10;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_req = state_q == ACCESS;
  assign bus.mem_we = state_q == ACCESS && we_q;
  assign bus.mem_be = be_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err = state_q == RESP ? err_q : 2'b00;
  assign bus.resp_rdata = state_q == RESP ? rdata_q : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: vector table, byte-level reference model and corner sequences for riscv_lsu
module tb_riscv_lsu;
  typedef struct {
    logic [1:0]  err;
    logic [63:0] rdata;
    logic [7:0]  be;
    logic [31:0] maddr;
    logic [63:0] mwdata;
    logic        we;
    int          cyc;
    int          lat;
  } res_t;
  typedef struct {
    bit          sel;
    bit          we;
    bit [1:0]    size;
    bit          uns;
    bit [31:0]   addr;
    bit [63:0]   wd;
    bit [63:0]   rd;
    int          lat;
    res_t        exp;
  } tv_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic t_sel = 1'b0, t_valid = 1'b0, t_we = 1'b0, t_uns = 1'b0, t_ack = 1'b0;
  logic [1:0] t_size = '0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_wdata = '0, t_rdata = '0;
  int checks = 0;
  int errors = 0;
  riscv_lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  riscv_lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();
  riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));
  always #5 clk = ~clk;
  assign b32.req_valid = t_valid & ~t_sel;
  assign b32.req_we = t_we;
  assign b32.req_size = t_size;
  assign b32.req_unsigned = t_uns;
  assign b32.req_addr = t_addr;
  assign b32.req_wdata = t_wdata[31:0];
  assign b32.mem_ack = t_ack & ~t_sel;
  assign b32.mem_rdata = t_rdata[31:0];
  assign b64.req_valid = t_valid & t_sel;
  assign b64.req_we = t_we;
  assign b64.req_size = t_size;
  assign b64.req_unsigned = t_uns;
  assign b64.req_addr = t_addr;
  assign b64.req_wdata = t_wdata;
  assign b64.mem_ack = t_ack & t_sel;
  assign b64.mem_rdata = t_rdata;
  logic o_req, o_we, o_ready, o_valid;
  logic [1:0] o_err;
  logic [7:0] o_be;
  logic [31:0] o_addr;
  logic [63:0] o_wdata, o_rdata;
  assign o_req = t_sel ? b64.mem_req : b32.mem_req;
  assign o_we = t_sel ? b64.mem_we : b32.mem_we;
  assign o_ready = t_sel ? b64.req_ready : b32.req_ready;
  assign o_valid = t_sel ? b64.resp_valid : b32.resp_valid;
  assign o_err = t_sel ? b64.resp_err : b32.resp_err;
  assign o_be = t_sel ? b64.mem_be : {4'b0, b32.mem_be};
  assign o_addr = t_sel ? b64.mem_addr : b32.mem_addr;
  assign o_wdata = t_sel ? b64.mem_wdata : {32'b0, b32.mem_wdata};
  assign o_rdata = t_sel ? b64.resp_rdata : {32'b0, b32.resp_rdata};
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  // Reference: works byte by byte from the access rules, independent of any shifter structure.
  function automatic res_t model(bit sel, bit we, bit [1:0] size, bit uns, bit [31:0] addr,
                                 bit [63:0] wd, bit [63:0] rd, int lat);
    res_t r;
    int nb = sel ? 8 : 4;
    int to = sel ? 255 : 4;
    int bytes = 1 << size;
    int off;
    logic [63:0] v, nbm;
    r = '{default: '0};
    r.we = we;
    r.lat = 1;
    nbm = nb == 8 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    if (addr % bytes != 0 || bytes > nb) begin
      r.err = 2'b01;
      return r;
    end
    off = int'(addr % nb);
    r.maddr = addr - off;
    r.be = 8'(((1 << bytes) - 1) << off);
    r.mwdata = (wd << (8 * off)) & nbm;
    if (lat == 0 || lat > to) begin
      r.err = 2'b10;
      r.cyc = to;
      r.lat = to + 1;
      return r;
    end
    r.cyc = lat;
    r.lat = lat + 1;
    if (!we) begin
      v = '0;
      for (int i = 0; i < bytes; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!uns && v[8*bytes-1])
        for (int i = bytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
      r.rdata = v & nbm;
    end
    return r;
  endfunction
  task automatic run(input bit sel, input bit we, input bit [1:0] size, input bit uns,
                     input bit [31:0] addr, input bit [63:0] wd, input bit [63:0] rd,
                     input int lat, output res_t r);
    bit done = 0;
    bit unstable = 0;
    r = '{default: '0};
    @(negedge clk);
    t_sel = sel;
    chk("ready_idle", o_ready, 1);
    t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wd; t_valid = 1;
    @(posedge clk); #1 t_valid = 0;
    for (int n = 1; n <= 300 && !done; n++) begin
      @(negedge clk);
      if (o_req) begin
        if (r.cyc == 0) begin
          r.be = o_be; r.maddr = o_addr; r.mwdata = o_wdata; r.we = o_we;
        end else if (o_be !== r.be || o_addr !== r.maddr || o_wdata !== r.mwdata || o_we !== r.we)
          unstable = 1;
        r.cyc++;
        if (r.cyc == lat) begin
          t_ack = 1; t_rdata = rd;
        end
      end
      if (o_valid) begin
        r.err = o_err; r.rdata = o_rdata; r.lat = n;
        chk("ready_in_resp", o_ready, 0);
        done = 1;
      end
      @(posedge clk); #1 t_ack = 0;
    end
    chk("bus_stable", unstable, 0);
    if (!done) begin
      checks++; errors++;
      $display("FAIL resp_wait: no resp_valid within 300 cycles");
    end else begin
      @(negedge clk);
      chk("resp_pulse", o_valid, 0);
    end
  endtask
  task automatic cmp(input string tag, input res_t a, input res_t e);
    chk({tag, " err"}, 64'(a.err), 64'(e.err));
    chk({tag, " rdata"}, a.rdata, e.rdata);
    chk({tag, " req_cycles"}, 64'(a.cyc), 64'(e.cyc));
    chk({tag, " latency"}, 64'(a.lat), 64'(e.lat));
    if (e.cyc > 0) begin
      chk({tag, " be"}, 64'(a.be), 64'(e.be));
      chk({tag, " addr"}, 64'(a.maddr), 64'(e.maddr));
      chk({tag, " wdata"}, a.mwdata, e.mwdata);
      chk({tag, " we"}, 64'(a.we), 64'(e.we));
    end
  endtask
  tv_t tv[11];
  res_t got, exp_r;
  initial begin
    tv[0]  = '{0, 1, 2'd2, 0, 32'h104, 64'hDEADBEEF, 64'h0, 3, '{2'd0, 64'h0, 8'hF, 32'h104, 64'hDEADBEEF, 1'b1, 3, 4}};
    tv[1]  = '{0, 0, 2'd0, 0, 32'h103, 64'h0, 64'h80112233, 1, '{2'd0, 64'hFFFFFF80, 8'h8, 32'h100, 64'h0, 1'b0, 1, 2}};
    tv[2]  = '{0, 0, 2'd0, 1, 32'h103, 64'h0, 64'h80112233, 1, '{2'd0, 64'h00000080, 8'h8, 32'h100, 64'h0, 1'b0, 1, 2}};
    tv[3]  = '{0, 1, 2'd1, 0, 32'h102, 64'h1234, 64'h0, 1, '{2'd0, 64'h0, 8'hC, 32'h100, 64'h12340000, 1'b1, 1, 2}};
    tv[4]  = '{0, 0, 2'd1, 0, 32'h101, 64'h0, 64'h0, 1, '{2'd1, 64'h0, 8'h0, 32'h0, 64'h0, 1'b0, 0, 1}};
    tv[5]  = '{0, 0, 2'd3, 0, 32'h8, 64'h0, 64'h0, 1, '{2'd1, 64'h0, 8'h0, 32'h0, 64'h0, 1'b0, 0, 1}};
    tv[6]  = '{1, 0, 2'd3, 0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 2, '{2'd0, 64'h0123456789ABCDEF, 8'hFF, 32'h8, 64'h0, 1'b0, 2, 3}};
    tv[7]  = '{0, 0, 2'd2, 0, 32'h200, 64'h0, 64'h0, 0, '{2'd2, 64'h0, 8'hF, 32'h200, 64'h0, 1'b0, 4, 5}};
    tv[8]  = '{1, 0, 2'd2, 0, 32'h14, 64'h0, 64'h80000001_00000000, 2, '{2'd0, 64'hFFFFFFFF80000001, 8'hF0, 32'h10, 64'h0, 1'b0, 2, 3}};
    tv[9]  = '{1, 0, 2'd2, 1, 32'h14, 64'h0, 64'h80000001_00000000, 2, '{2'd0, 64'h0000000080000001, 8'hF0, 32'h10, 64'h0, 1'b0, 2, 3}};
    tv[10] = '{0, 1, 2'd0, 0, 32'h101, 64'hAB, 64'h0, 1, '{2'd0, 64'h0, 8'h2, 32'h100, 64'h0000AB00, 1'b1, 1, 2}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready32", b32.req_ready, 1);
    chk("rst ready64", b64.req_ready, 1);
    chk("rst valid", {b32.resp_valid, b64.resp_valid}, 0);
    chk("rst mem_req", {b32.mem_req, b64.mem_req, b32.mem_we, b64.mem_we}, 0);
    chk("rst be", {b32.mem_be, b64.mem_be}, 0);
    chk("rst addr", {b32.mem_addr, b64.mem_addr}, 0);
    chk("rst wdata64", b64.mem_wdata, 0);
    chk("rst resp", {b32.resp_rdata, b32.resp_err, b64.resp_err}, 0);
    rst = 1;
    for (int i = 0; i < 11; i++) begin
      run(tv[i].sel, tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wd, tv[i].rd, tv[i].lat, got);
      cmp($sformatf("vec%0d", i), got, tv[i].exp);
    end
    // late ack after a timeout must not produce a response
    run(0, 0, 2'd2, 0, 32'h40, 64'h0, 64'h0, 0, got);
    cmp("timeout", got, model(0, 0, 2'd2, 0, 32'h40, 64'h0, 64'h0, 0));
    t_ack = 1; t_rdata = 64'h5555AAAA;
    @(negedge clk);
    chk("late_ack valid", o_valid, 0);
    chk("late_ack req", o_req, 0);
    chk("late_ack ready", o_ready, 1);
    t_ack = 0;
    // reset while the access is outstanding
    @(negedge clk);
    t_sel = 0; t_we = 0; t_size = 2'd2; t_uns = 0; t_addr = 32'h300; t_valid = 1;
    @(posedge clk); #1 t_valid = 0;
    @(negedge clk);
    chk("pre_rst req", o_req, 1);
    rst = 0;
    @(negedge clk);
    chk("rst_access req", o_req, 0);
    chk("rst_access ready", o_ready, 1);
    chk("rst_access valid", o_valid, 0);
    chk("rst_access be", o_be, 0);
    chk("rst_access addr", o_addr, 0);
    rst = 1;
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (o_valid) seen++;
      end
      chk("rst_no_resp", seen, 0);
    end
    run(0, 0, 2'd1, 0, 32'h306, 64'h0, 64'h9ABC0000, 2, got);
    cmp("post_rst", got, model(0, 0, 2'd1, 0, 32'h306, 64'h0, 64'h9ABC0000, 2));
    for (int i = 0; i < 150; i++) begin
      bit sel = 1'($urandom_range(0, 1));
      bit we = 1'($urandom_range(0, 1));
      bit [1:0] size = 2'($urandom_range(0, 3));
      bit uns = 1'($urandom_range(0, 1));
      bit [31:0] addr = 32'h1000 + $urandom_range(0, 255);
      bit [63:0] wd = {$urandom, $urandom};
      bit [63:0] rd = {$urandom, $urandom};
      int lat = sel ? $urandom_range(1, 4) : $urandom_range(0, 5);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      run(sel, we, size, uns, addr, wd, rd, lat, got);
      exp_r = model(sel, we, size, uns, addr, wd, rd, lat);
      cmp($sformatf("rnd%0d", i), got, exp_r);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
